// File: rtl/ibtfly_2_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : ibtfly_pkg                                                     |
// | Shared definitions for the streaming inverse radix-2 butterfly:          |
// | FSM state encoding and the default component width.                     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package ibtfly_pkg;

  // Default width of each signed S/D and x0/x1 component
  localparam int NB_INPUT_DEF = 9;

  // Stream FSM state encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // waiting for S
    HAVE_S = 2'd1,  // S held, waiting for D
    EMIT0  = 2'd2,  // presenting x0
    EMIT1  = 2'd3   // presenting x1 (last beat of pair)
  } state_t;

endpackage : ibtfly_pkg
`default_nettype wire

// File: rtl/ibtfly_2_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : ibtfly_2_stream_if                                           |
// | Input and output valid/ready streams of the inverse butterfly.           |
// |   slave  : block view (consumes i_*, drives o_*)                         |
// |   master : environment view (drives i_*, consumes o_*)                   |
// |   i_valid/o_ready/i_data_r/i_data_i : S on even beats, D on odd beats    |
// |   o_valid/i_ready/o_data_r/o_data_i : x0 then x1                         |
// |   o_last : high on the x1 beat; o_err : parity error of the pair         |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface ibtfly_2_stream_if #(
  parameter int NB_INPUT = ibtfly_pkg::NB_INPUT_DEF
);
  logic                       i_valid;
  logic                       o_ready;
  logic signed [NB_INPUT-1:0] i_data_r;
  logic signed [NB_INPUT-1:0] i_data_i;
  logic                       o_valid;
  logic                       i_ready;
  logic signed [NB_INPUT-1:0] o_data_r;
  logic signed [NB_INPUT-1:0] o_data_i;
  logic                       o_last;
  logic                       o_err;

  modport slave (
    input  i_valid, i_data_r, i_data_i, i_ready,
    output o_ready, o_valid, o_data_r, o_data_i, o_last, o_err
  );

  modport master (
    output i_valid, i_data_r, i_data_i, i_ready,
    input  o_ready, o_valid, o_data_r, o_data_i, o_last, o_err
  );
endinterface : ibtfly_2_stream_if
`default_nettype wire

// File: rtl/ibtfly_2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ibtfly_2                                                        |
// | Combinational inverse radix-2 butterfly core.                            |
// |   i_s_r/i_s_i : S = x0+x1     i_d_r/i_d_i : D = x0-x1                    |
// |   o_x0_r/i    : (S+D)>>>1     o_x1_r/i    : (S-D)>>>1                    |
// |   o_err       : S+D odd in either component (corrupted pair)             |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module ibtfly_2 #(
  parameter int NB_INPUT = ibtfly_pkg::NB_INPUT_DEF
) (
  input  wire logic signed [NB_INPUT-1:0] i_s_r,
  input  wire logic signed [NB_INPUT-1:0] i_s_i,
  input  wire logic signed [NB_INPUT-1:0] i_d_r,
  input  wire logic signed [NB_INPUT-1:0] i_d_i,
  output logic signed [NB_INPUT-1:0]      o_x0_r,
  output logic signed [NB_INPUT-1:0]      o_x0_i,
  output logic signed [NB_INPUT-1:0]      o_x1_r,
  output logic signed [NB_INPUT-1:0]      o_x1_i,
  output logic                            o_err
);

  // One growth bit: S+D and S-D cannot overflow NB_INPUT+1 bits
  logic signed [NB_INPUT:0] w_sum_r;
  logic signed [NB_INPUT:0] w_sum_i;
  logic signed [NB_INPUT:0] w_dif_r;
  logic signed [NB_INPUT:0] w_dif_i;

  always_comb begin
    w_sum_r = {i_s_r[NB_INPUT-1], i_s_r} + {i_d_r[NB_INPUT-1], i_d_r};
    w_sum_i = {i_s_i[NB_INPUT-1], i_s_i} + {i_d_i[NB_INPUT-1], i_d_i};
    w_dif_r = {i_s_r[NB_INPUT-1], i_s_r} - {i_d_r[NB_INPUT-1], i_d_r};
    w_dif_i = {i_s_i[NB_INPUT-1], i_s_i} - {i_d_i[NB_INPUT-1], i_d_i};
  end

  // Dropping the LSB of a two's complement value is an arithmetic
  // shift right by one, i.e. floor division by two.
  assign o_x0_r = w_sum_r[NB_INPUT:1];
  assign o_x0_i = w_sum_i[NB_INPUT:1];
  assign o_x1_r = w_dif_r[NB_INPUT:1];
  assign o_x1_i = w_dif_i[NB_INPUT:1];

  // The LSB of both S+D and S-D equals S[0]^D[0], so AND-ing the two
  // LSBs is the same parity test and consumes every computed bit.
  assign o_err = (w_sum_r[0] & w_dif_r[0]) | (w_sum_i[0] & w_dif_i[0]);

endmodule : ibtfly_2
`default_nettype wire

// File: rtl/ibtfly_2_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ibtfly_2_stream                                                 |
// | Streaming inverse radix-2 butterfly. Collects a serial (S, D) pair,      |
// | reconstructs x0=(S+D)/2 and x1=(S-D)/2 and emits them as two beats.      |
// |   i_clock : rising-edge clock                                            |
// |   i_reset : synchronous active-high reset                                |
// |   bus     : input/output streams (slave view of ibtfly_2_stream_if)      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module ibtfly_2_stream
  import ibtfly_pkg::*;
#(
  parameter int NB_INPUT = NB_INPUT_DEF
) (
  input wire logic          i_clock,
  input wire logic          i_reset,
  ibtfly_2_stream_if.slave  bus
);

  state_t                     r_state;
  logic signed [NB_INPUT-1:0] r_s_r;
  logic signed [NB_INPUT-1:0] r_s_i;
  logic signed [NB_INPUT-1:0] r_x1_r;
  logic signed [NB_INPUT-1:0] r_x1_i;
  logic signed [NB_INPUT-1:0] r_data_r;
  logic signed [NB_INPUT-1:0] r_data_i;
  logic                       r_valid;
  logic                       r_last;
  logic                       r_err;

  logic signed [NB_INPUT-1:0] w_x0_r;
  logic signed [NB_INPUT-1:0] w_x0_i;
  logic signed [NB_INPUT-1:0] w_x1_r;
  logic signed [NB_INPUT-1:0] w_x1_i;
  logic                       w_err;
  logic                       w_ready;

  // D is used straight from the input bus so the results can be
  // registered on the same edge that accepts D.
  ibtfly_2 #(
    .NB_INPUT (NB_INPUT)
  ) u_core (
    .i_s_r  (r_s_r),
    .i_s_i  (r_s_i),
    .i_d_r  (bus.i_data_r),
    .i_d_i  (bus.i_data_i),
    .o_x0_r (w_x0_r),
    .o_x0_i (w_x0_i),
    .o_x1_r (w_x1_r),
    .o_x1_i (w_x1_i),
    .o_err  (w_err)
  );

  // Ready depends on state only: no combinational path from i_ready
  assign w_ready = (r_state == IDLE) || (r_state == HAVE_S);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_s_r    <= '0;
      r_s_i    <= '0;
      r_x1_r   <= '0;
      r_x1_i   <= '0;
      r_data_r <= '0;
      r_data_i <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_valid) begin
            r_s_r   <= bus.i_data_r;
            r_s_i   <= bus.i_data_i;
            r_state <= HAVE_S;
          end
        end
        HAVE_S: begin
          if (bus.i_valid) begin
            r_data_r <= w_x0_r;
            r_data_i <= w_x0_i;
            r_x1_r   <= w_x1_r;
            r_x1_i   <= w_x1_i;
            r_err    <= w_err;
            r_last   <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= EMIT0;
          end
        end
        EMIT0: begin
          if (bus.i_ready) begin
            r_data_r <= r_x1_r;
            r_data_i <= r_x1_i;
            r_last   <= 1'b1;
            r_state  <= EMIT1;
          end
        end
        EMIT1: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready  = w_ready;
  assign bus.o_valid  = r_valid;
  assign bus.o_data_r = r_data_r;
  assign bus.o_data_i = r_data_i;
  assign bus.o_last   = r_last;
  assign bus.o_err    = r_err;

endmodule : ibtfly_2_stream
`default_nettype wire
